alu_seq_mdu: RTL

//  Parametrised successor to the single-cycle ALU: registered logic/arith ops plus iterative multiply/divide.

---
 rtl/alu_seq_mdu.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_mdu.sv
// alu_seq_mdu: registered ALU with iterative multiply/divide for the EX stage.
//   Single-cycle ops complete one edge after an accepted start. mult/multu
//   (and div/divu when ALU_SEQ_DIV_EN is defined) run WIDTH shift iterations
//   on operand magnitudes, then a fix-up cycle applies sign correction.
//   Without ALU_SEQ_DIV_EN, div/divu return zero as single-cycle ops.
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   start, aluCtr         op request (sampled when not busy) and op code
//   input1, input2        operands A and B, latched at acceptance
//   aluRes, hiRes         primary result / high product or remainder
//   zero, ovf             aluRes==0, signed add/sub overflow
//   busy, done            sequential op in flight / one-cycle completion pulse
module alu_seq_mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       aluCtr,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic [WIDTH-1:0] aluRes,
    output logic [WIDTH-1:0] hiRes,
    output logic             zero,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MULT  = 4'b1010;
    localparam logic [3:0] OP_MULTU = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_UNDEF = 4'b1111;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] hi_r, lo_r, d_r;
    logic             neg_lo_r;
`ifdef ALU_SEQ_DIV_EN
    logic             is_div_r, neg_hi_r, bzero_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH:0]   div_trial;
`endif

    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   sum, diff, sc_res, mag_a, mag_b, fix_lo, fix_hi;
    logic               sc_ovf, is_seq_c, signed_op_c;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] full_neg;

    // Single-cycle result path
    always_comb begin
        shamt  = input2[SHW-1:0];
        sum    = input1 + input2;
        diff   = input1 - input2;
        sc_res = '0;
        sc_ovf = 1'b0;
        case (aluCtr)
            OP_AND:  sc_res = input1 & input2;
            OP_OR:   sc_res = input1 | input2;
            OP_XOR:  sc_res = input1 ^ input2;
            OP_NOR:  sc_res = ~(input1 | input2);
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (input1[WIDTH-1] == input2[WIDTH-1]) && (sum[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (input1[WIDTH-1] != input2[WIDTH-1]) && (diff[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_SLT:  sc_res = WIDTH'($signed(input1) < $signed(input2));
            OP_SLTU: sc_res = WIDTH'(input1 < input2);
            OP_SLL:  sc_res = input1 << shamt;
            OP_SRL:  sc_res = input1 >> shamt;
            OP_SRA:  sc_res = $signed(input1) >>> shamt;
            // div/divu only reach here when the divider is compiled out
            OP_DIV, OP_DIVU, OP_UNDEF: sc_res = '0;
            default: sc_res = '0;
        endcase
    end

    // Operand magnitudes and op classification for the iterative path
    always_comb begin
        signed_op_c = (aluCtr == OP_MULT);
        is_seq_c    = (aluCtr == OP_MULT) || (aluCtr == OP_MULTU);
`ifdef ALU_SEQ_DIV_EN
        signed_op_c = signed_op_c || (aluCtr == OP_DIV);
        is_seq_c    = is_seq_c || (aluCtr == OP_DIV) || (aluCtr == OP_DIVU);
`endif
        mag_a = (signed_op_c && input1[WIDTH-1]) ? -input1 : input1;
        mag_b = (signed_op_c && input2[WIDTH-1]) ? -input2 : input2;
    end

    // Iteration step and final sign correction
    always_comb begin
        mul_sum  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, d_r} : (WIDTH+1)'(0));
        full_neg = -{hi_r, lo_r};
        fix_lo   = neg_lo_r ? full_neg[WIDTH-1:0] : lo_r;
        fix_hi   = neg_lo_r ? full_neg[2*WIDTH-1:WIDTH] : hi_r;
`ifdef ALU_SEQ_DIV_EN
        // Restoring step: bit WIDTH set means the trial subtraction borrowed
        div_trial = {hi_r, lo_r[WIDTH-1]} - {1'b0, d_r};
        if (is_div_r) begin
            if (bzero_r) begin
                fix_lo = '1;
                fix_hi = a_r;
            end else begin
                fix_lo = neg_lo_r ? -lo_r : lo_r;
                fix_hi = neg_hi_r ? -hi_r : hi_r;
            end
        end
`endif
    end

    // Control FSM and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            d_r      <= '0;
            neg_lo_r <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            is_div_r <= 1'b0;
            neg_hi_r <= 1'b0;
            bzero_r  <= 1'b0;
            a_r      <= '0;
`endif
            aluRes   <= '0;
            hiRes    <= '0;
            zero     <= 1'b1;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_seq_c) begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            cnt      <= '0;
                            hi_r     <= '0;
                            lo_r     <= mag_a;
                            d_r      <= mag_b;
                            neg_lo_r <= signed_op_c && (input1[WIDTH-1] ^ input2[WIDTH-1]);
`ifdef ALU_SEQ_DIV_EN
                            is_div_r <= (aluCtr == OP_DIV) || (aluCtr == OP_DIVU);
                            neg_hi_r <= signed_op_c && input1[WIDTH-1];
                            bzero_r  <= (input2 == '0);
                            a_r      <= input1;
`endif
                        end else begin
                            aluRes <= sc_res;
                            hiRes  <= '0;
                            zero   <= (sc_res == '0);
                            ovf    <= sc_ovf;
                            done   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + SHW'(1);
                    if (cnt == SHW'(WIDTH-1)) state <= FIX;
`ifdef ALU_SEQ_DIV_EN
                    if (is_div_r) begin
                        if (!div_trial[WIDTH]) begin
                            hi_r <= div_trial[WIDTH-1:0];
                            lo_r <= {lo_r[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_r <= {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};
                            lo_r <= {lo_r[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        hi_r <= mul_sum[WIDTH:1];
                        lo_r <= {mul_sum[0], lo_r[WIDTH-1:1]};
                    end
`else
                    hi_r <= mul_sum[WIDTH:1];
                    lo_r <= {mul_sum[0], lo_r[WIDTH-1:1]};
`endif
                end
                FIX: begin
                    aluRes <= fix_lo;
                    hiRes  <= fix_hi;
                    zero   <= (fix_lo == '0);
                    ovf    <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
